// File: rtl/cc_level_tracker.sv
// Registered score-to-level tracker: debounced promotion/demotion with hysteresis,
// single-cycle level-change pulses and an optional monotonic (no-demotion) mode.
module cc_level_tracker #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned NUM_LEVELS  = 3,
    parameter int unsigned LEVEL_WIDTH = 2,
    parameter logic [(NUM_LEVELS-1)*DATA_WIDTH-1:0] THRESHOLDS = {8'd30, 8'd10},
    parameter logic [DATA_WIDTH-1:0] HYST = 4,
    parameter int unsigned HOLD_CYCLES = 3
) (
    input  logic                   CC_LEVEL_TRACKER_CLOCK_50,
    input  logic                   CC_LEVEL_TRACKER_RESET_InLow,
    input  logic                   CC_LEVEL_TRACKER_Clear_InLow,
    input  logic                   CC_LEVEL_TRACKER_Monotonic_In,
    input  logic                   CC_LEVEL_TRACKER_Valid_In,
    input  logic [DATA_WIDTH-1:0]  CC_LEVEL_TRACKER_BusIn,
    output logic [LEVEL_WIDTH-1:0] CC_LEVEL_TRACKER_Level_OutBus,
    output logic                   CC_LEVEL_TRACKER_LevelUp_Out,
    output logic                   CC_LEVEL_TRACKER_LevelDown_Out,
    output logic                   CC_LEVEL_TRACKER_Pending_Out
);

    localparam int unsigned CntWidth = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES + 1) : 1;
    localparam logic [CntWidth-1:0] HoldVal = CntWidth'(HOLD_CYCLES);
    localparam logic [LEVEL_WIDTH-1:0] LevelMin = LEVEL_WIDTH'(1);
    localparam logic [LEVEL_WIDTH-1:0] LevelMax = LEVEL_WIDTH'(NUM_LEVELS);

    typedef enum logic [1:0] {
        StStable,
        StPromotePend,
        StDemotePend
    } state_e;

    state_e                 state_q, state_d;
    logic [CntWidth-1:0]    cnt_q, cnt_d;
    logic [LEVEL_WIDTH-1:0] level_q, level_d;
    logic                   up_pulse_q, up_pulse_d;
    logic                   dn_pulse_q, dn_pulse_d;
    logic                   pending_q, pending_d;

    logic [DATA_WIDTH-1:0]  up_thr;
    logic [DATA_WIDTH-1:0]  dn_thr;
    logic [DATA_WIDTH:0]    bus_plus_hyst;
    logic                   up_hit;
    logic                   dn_hit;
    logic [CntWidth-1:0]    cnt_inc;
    logic                   eval_stable;

    // Select T[L-1] (promotion) and T[L-2] (demotion) for the current level.
    always_comb begin
        up_thr = '0;
        dn_thr = '0;
        for (int k = 0; k < int'(NUM_LEVELS) - 1; k++) begin
            if (int'(level_q) == k + 1) up_thr = THRESHOLDS[k*DATA_WIDTH +: DATA_WIDTH];
            if (int'(level_q) == k + 2) dn_thr = THRESHOLDS[k*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_comb begin
        bus_plus_hyst = {1'b0, CC_LEVEL_TRACKER_BusIn} + {1'b0, HYST};
        up_hit = (level_q < LevelMax) && (CC_LEVEL_TRACKER_BusIn > up_thr);
        dn_hit = (level_q > LevelMin) && !CC_LEVEL_TRACKER_Monotonic_In &&
                 (bus_plus_hyst <= {1'b0, dn_thr});
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        level_d     = level_q;
        up_pulse_d  = 1'b0;
        dn_pulse_d  = 1'b0;
        eval_stable = 1'b0;
        cnt_inc     = cnt_q + 1'b1;

        if (CC_LEVEL_TRACKER_Valid_In) begin
            unique case (state_q)
                StStable: eval_stable = 1'b1;
                StPromotePend: begin
                    if (up_hit) begin
                        if (cnt_inc == HoldVal) begin
                            level_d    = level_q + 1'b1;
                            up_pulse_d = 1'b1;
                            cnt_d      = '0;
                            state_d    = StStable;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else begin
                        cnt_d       = '0;
                        state_d     = StStable;
                        eval_stable = 1'b1;
                    end
                end
                StDemotePend: begin
                    if (dn_hit) begin
                        if (cnt_inc == HoldVal) begin
                            level_d    = level_q - 1'b1;
                            dn_pulse_d = 1'b1;
                            cnt_d      = '0;
                            state_d    = StStable;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else begin
                        cnt_d       = '0;
                        state_d     = StStable;
                        eval_stable = 1'b1;
                    end
                end
                default: begin
                    cnt_d   = '0;
                    state_d = StStable;
                end
            endcase

            // A run broken in a pending state restarts from STABLE on the same sample.
            if (eval_stable) begin
                if (up_hit) begin
                    if (HOLD_CYCLES == 1) begin
                        level_d    = level_q + 1'b1;
                        up_pulse_d = 1'b1;
                    end else begin
                        cnt_d   = CntWidth'(1);
                        state_d = StPromotePend;
                    end
                end else if (dn_hit) begin
                    if (HOLD_CYCLES == 1) begin
                        level_d    = level_q - 1'b1;
                        dn_pulse_d = 1'b1;
                    end else begin
                        cnt_d   = CntWidth'(1);
                        state_d = StDemotePend;
                    end
                end
            end
        end

        if (!CC_LEVEL_TRACKER_Clear_InLow) begin
            level_d    = LevelMin;
            state_d    = StStable;
            cnt_d      = '0;
            up_pulse_d = 1'b0;
            dn_pulse_d = 1'b0;
        end

        pending_d = (state_d != StStable);
    end

    always_ff @(posedge CC_LEVEL_TRACKER_CLOCK_50) begin
        if (!CC_LEVEL_TRACKER_RESET_InLow) begin
            state_q    <= StStable;
            cnt_q      <= '0;
            level_q    <= LevelMin;
            up_pulse_q <= 1'b0;
            dn_pulse_q <= 1'b0;
            pending_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            level_q    <= level_d;
            up_pulse_q <= up_pulse_d;
            dn_pulse_q <= dn_pulse_d;
            pending_q  <= pending_d;
        end
    end

    assign CC_LEVEL_TRACKER_Level_OutBus  = level_q;
    assign CC_LEVEL_TRACKER_LevelUp_Out   = up_pulse_q;
    assign CC_LEVEL_TRACKER_LevelDown_Out = dn_pulse_q;
    assign CC_LEVEL_TRACKER_Pending_Out   = pending_q;

endmodule

// File: tb/tb_cc_level_tracker.sv
// Scoreboard bench for cc_level_tracker: a run-length reference model predicts each
// post-edge output set; a monitor pops and compares one prediction per clock.
module tb_cc_level_tracker;

    localparam int NL   = 3;
    localparam int HOLD = 3;
    localparam int HYS  = 4;

    typedef struct packed {
        logic [1:0] level;
        logic       up;
        logic       dn;
        logic       pend;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clr_n = 1'b1;
    logic       mono = 1'b0;
    logic       valid = 1'b0;
    logic [7:0] bus = 8'd0;
    logic [1:0] level;
    logic       up_o, dn_o, pend_o;

    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];

    // Reference state: current level plus the direction/length of the qualifying run.
    int thr[NL-1] = '{10, 30};
    int m_level = 1;
    int m_dir = 0;
    int m_len = 0;

    cc_level_tracker #(
        .DATA_WIDTH (8),
        .NUM_LEVELS (3),
        .LEVEL_WIDTH(2),
        .THRESHOLDS ({8'd30, 8'd10}),
        .HYST       (8'd4),
        .HOLD_CYCLES(3)
    ) dut (
        .CC_LEVEL_TRACKER_CLOCK_50     (clk),
        .CC_LEVEL_TRACKER_RESET_InLow  (rst_n),
        .CC_LEVEL_TRACKER_Clear_InLow  (clr_n),
        .CC_LEVEL_TRACKER_Monotonic_In (mono),
        .CC_LEVEL_TRACKER_Valid_In     (valid),
        .CC_LEVEL_TRACKER_BusIn        (bus),
        .CC_LEVEL_TRACKER_Level_OutBus (level),
        .CC_LEVEL_TRACKER_LevelUp_Out  (up_o),
        .CC_LEVEL_TRACKER_LevelDown_Out(dn_o),
        .CC_LEVEL_TRACKER_Pending_Out  (pend_o)
    );

    always #5 clk = ~clk;

    function automatic void chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // Drive one cycle of inputs and push the model's prediction for the next edge.
    task automatic cycle(input logic r, input logic c, input logic m, input logic v,
                         input int b);
        exp_t e;
        int   want;
        @(negedge clk);
        rst_n = r;
        clr_n = c;
        mono  = m;
        valid = v;
        bus   = 8'(b);
        e.up  = 1'b0;
        e.dn  = 1'b0;
        if (!r || !c) begin
            m_level = 1;
            m_dir   = 0;
            m_len   = 0;
        end else if (v) begin
            want = 0;
            if (m_level < NL && b > thr[(m_level < NL) ? m_level - 1 : 0])
                want = 1;
            else if (m_level > 1 && !m && b + HYS <= thr[(m_level > 1) ? m_level - 2 : 0])
                want = -1;
            if (want == 0) begin
                m_dir = 0;
                m_len = 0;
            end else begin
                if (m_dir == want) m_len++;
                else begin
                    m_dir = want;
                    m_len = 1;
                end
                if (m_len == HOLD) begin
                    m_level += want;
                    if (want > 0) e.up = 1'b1;
                    else e.dn = 1'b1;
                    m_dir = 0;
                    m_len = 0;
                end
            end
        end
        e.level = 2'(m_level);
        e.pend  = (m_len > 0);
        sb_q.push_back(e);
    endtask

    task automatic run(input int n, input int b);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b1, 1'b0, 1'b1, b);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, 0);
    endtask

    task automatic do_reset();
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 0);
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 200);
    endtask

    // Monitor: every clock the DUT presents a full output set; compare against the queue.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("level", int'(level), int'(e.level));
                chk("level_up", int'(up_o), int'(e.up));
                chk("level_down", int'(dn_o), int'(e.dn));
                chk("pending", int'(pend_o), int'(e.pend));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        do_reset();
        run(6, 5);                      // stays at level 1
        run(3, 11);                     // 1 -> 2
        idle(2);
        run(7, 200);                    // 2 -> 3, then saturate
        run(5, 28);                     // hysteresis blocks demotion
        run(3, 26);                     // 3 -> 2
        run(3, 200);                    // back to 3
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1, 1'b1, 1'b1, 0);
        do_reset();
        run(2, 11); run(1, 9); run(2, 11);   // debounce breaks the run
        do_reset();
        run(1, 11); idle(1); run(1, 11); idle(2); run(1, 11);  // gaps keep the run
        run(2, 31);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 31);   // clear beats the qualifying step
        idle(1);
        run(2, 11);
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 11);   // reset mid-pending
        idle(1);
        run(3, 200); run(2, 0);
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 0);    // monotonic aborts a demotion run
        run(3, 0);

        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 99);
            cycle((r == 0) ? 1'b0 : 1'b1,
                  ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1,
                  ($urandom_range(0, 99) < 10) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 99) < 75) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 255))
                                              : int'($urandom_range(0, 40)));
        end
        idle(2);

        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d predictions left, expected 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cc_level_tracker.md
# cc_level_tracker

Registered, parametrised successor to the combinational score-to-level comparator. It samples a score bus and keeps a difficulty level between 1 and NUM_LEVELS. A level changes only after a debounced threshold crossing, and demotion uses hysteresis. Single-cycle level-up and level-down pulses go to the game controller, and a monotonic mode blocks demotion. It sits between the score counter and the speed/spawn logic.

## Interface
- DATA_WIDTH, 8: width of the score bus.
- NUM_LEVELS, 3: number of levels, ≥2. Output level range is 1..NUM_LEVELS.
- LEVEL_WIDTH, 2: width of the level output. Must satisfy 2^LEVEL_WIDTH > NUM_LEVELS.
- THRESHOLDS, {8'd30, 8'd10}: packed vector of (NUM_LEVELS-1)×DATA_WIDTH bits.
  - Slice k (LSB first) is T[k], the promotion threshold from level k+1 to level k+2.
  - Values must be strictly ascending.
- HYST, 4: demotion hysteresis, DATA_WIDTH bits.
- HOLD_CYCLES, 3: consecutive qualifying valid samples required before a step, ≥1.
- CC_LEVEL_TRACKER_CLOCK_50  in  1  system clock; all logic on its rising edge.
- CC_LEVEL_TRACKER_RESET_InLow  in  1  reset, synchronous, active-low.
- CC_LEVEL_TRACKER_Clear_InLow  in  1  synchronous return to level 1, active-low.
- CC_LEVEL_TRACKER_Monotonic_In  in  1  1 = demotion disabled.
- CC_LEVEL_TRACKER_Valid_In  in  1  score sample strobe.
- CC_LEVEL_TRACKER_BusIn  in  DATA_WIDTH  score, unsigned.
- CC_LEVEL_TRACKER_Level_OutBus  out  LEVEL_WIDTH  current level, 1..NUM_LEVELS.
- CC_LEVEL_TRACKER_LevelUp_Out  out  1  one-cycle pulse on promotion.
- CC_LEVEL_TRACKER_LevelDown_Out  out  1  one-cycle pulse on demotion.
- CC_LEVEL_TRACKER_Pending_Out  out  1  high while the FSM is in PROMOTE_PEND or DEMOTE_PEND.

## Operation
- L is the current level.
- Promotion condition (up_q) is true when L < NUM_LEVELS and BusIn > T[L-1].
- Demotion condition (dn_q) is true when all of the following hold:
  - L > 1
  - Monotonic_In = 0
  - (BusIn + HYST) ≤ T[L-2], evaluated at DATA_WIDTH+1 bits with no overflow.
- up_q and dn_q are mutually exclusive because thresholds ascend. If both are somehow computed true, up_q wins.
- FSM states: STABLE, PROMOTE_PEND, DEMOTE_PEND. Hold counter cnt is sized for HOLD_CYCLES.
- STABLE, on a valid sample:
  - up_q: cnt←1, go to PROMOTE_PEND.
  - dn_q: cnt←1, go to DEMOTE_PEND.
  - In both cases, if HOLD_CYCLES=1 the step happens immediately and the FSM stays in STABLE.
- PROMOTE_PEND, on a valid sample:
  - up_q: cnt increments. When cnt reaches HOLD_CYCLES: L←L+1, LevelUp pulses, cnt←0, go to STABLE.
  - Not up_q: cnt←0, go to STABLE. The same sample is re-evaluated from STABLE in that cycle, so an immediate dn_q starts DEMOTE_PEND with cnt=1.
- DEMOTE_PEND: mirror of PROMOTE_PEND using dn_q, L←L-1 and LevelDown.
- Cycles with Valid_In = 0 hold state and cnt unchanged. Gaps do not break a run.
- Level moves at most one step per qualification. A score that jumps several thresholds needs a fresh HOLD_CYCLES run for each step.
- Monotonic_In asserted during DEMOTE_PEND: the next valid sample sees dn_q false, so the FSM returns to STABLE with no step.
- Clear_InLow = 0 forces L=1, state STABLE, cnt=0, pulses 0. This overrides a simultaneous valid sample or qualifying step.
- Saturation: L never exceeds NUM_LEVELS and never drops below 1.

## Timing
- Reset (RESET_InLow=0 at a clock edge) sets:
  - Level_OutBus = 1
  - LevelUp_Out = 0, LevelDown_Out = 0
  - Pending_Out = 0
  - state STABLE, cnt = 0
- Reset mid-pending discards the run.
- All outputs are registered, with no combinational path from input to output.
- Latency: if the HOLD_CYCLES-th qualifying valid sample arrives at edge n, Level_OutBus changes and the pulse is high for exactly one cycle after edge n.
- Pending_Out rises one cycle after the first qualifying sample when HOLD_CYCLES > 1.
- Valid_In may be held high continuously. At 1 sample/cycle, a promotion completes HOLD_CYCLES cycles after the first qualifying sample.

## Test plan
Defaults apply unless noted (T = {30, 10}, HYST = 4, HOLD_CYCLES = 3).
- Reset then score 5 valid every cycle → Level = 1, no pulses, Pending = 0 throughout.
- Score 11 for 3 consecutive valid cycles → Level 1→2 one cycle after the 3rd sample. LevelUp high exactly 1 cycle.
- Score 200 held continuously from level 1 → Level = 2 after 3 samples, then 3 after 3 more. Two separate LevelUp pulses; Level never exceeds 3.
- Hysteresis from level 3:
  - Score 28 ×5 → no change (28+4 > 30).
  - Score 26 ×3 → Level 2 with a LevelDown pulse.
  - With Monotonic = 1, score 0 ×10 → Level stays 3.
- Debounce, score 11, 11, 9, 11, 11 from level 1:
  - No promotion, because the 9 resets the run (9+4 > 10, so the 9 also starts no demotion).
  - Interleaving Valid = 0 gaps inside a 3-sample run still promotes.
- Clear_InLow = 0 in the same cycle as the 3rd qualifying sample at level 2 → Level = 1, no LevelUp.
- RESET_InLow low while in PROMOTE_PEND → all outputs return to reset values on the next edge.
